// File: rtl/barrel_unshift.sv
// barrel_unshift: sequential inverse of the barrel_shift datapath.
// Takes a left-shifted word S and recovers the right-aligned word and the
// shift amount by shifting right one position per clock until the LSB is 1
// or the maximum representable shift is reached (minimal-k decode).
module barrel_unshift #(
  parameter int W  = 4,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  S,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  SW_out,
  output logic [KW-1:0] k_out,
  output logic          zero
);

  // Largest shift the counter can report and the word width allows.
  localparam int MAXK_CNT = (2 ** KW) - 1;
  localparam int MAXK     = (MAXK_CNT < (W - 1)) ? MAXK_CNT : (W - 1);
  localparam logic [KW-1:0] MAXK_K = KW'(MAXK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [W-1:0]  sr;
  logic [KW-1:0] cnt;
  logic          sr_zero;
  logic          stop_shift;

  assign sr_zero    = (sr == '0);
  assign stop_shift = sr_zero || sr[0] || (cnt == MAXK_K);

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured in IDLE and never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stop_shift) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Shift register and counter: load on accept, shift right while searching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (start) begin
          sr  <= S;
          cnt <= '0;
        end
      end else if (state == ST_SHIFT) begin
        if (!stop_shift) begin
          sr  <= sr >> 1;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Result registers: written only on the SHIFT->DONE transition, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SW_out <= '0;
      k_out  <= '0;
      zero   <= 1'b0;
    end else if (state == ST_SHIFT) begin
      if (sr_zero) begin
        SW_out <= '0;
        k_out  <= '0;
        zero   <= 1'b1;
      end else if (sr[0] || (cnt == MAXK_K)) begin
        SW_out <= sr;
        k_out  <= cnt;
        zero   <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_barrel_unshift.sv
// Scoreboard bench for barrel_unshift: stimulus pushes expected decodes,
// a negedge monitor pops and compares whenever done is presented.
module tb_barrel_unshift;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] S;
  logic       busy;
  logic       done;
  logic [3:0] SW_out;
  logic [1:0] k_out;
  logic       zero;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] sw;
    logic [1:0] k;
    logic       z;
    int         lat;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  barrel_unshift #(.W(4), .KW(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .S      (S),
    .busy   (busy),
    .done   (done),
    .SW_out (SW_out),
    .k_out  (k_out),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done seen with no request outstanding (SW_out=%b k_out=%0d)", SW_out, k_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (SW_out !== e.sw || k_out !== e.k || zero !== e.z || (cyc - e.acc) != e.lat) begin
          errors++;
          $display("FAIL decode: got SW_out=%b k_out=%0d zero=%b lat=%0d, want SW_out=%b k_out=%0d zero=%b lat=%0d",
                   SW_out, k_out, zero, cyc - e.acc, e.sw, e.k, e.z, e.lat);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Called at a negedge; waits for busy low with a bound.
  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, want 0", busy, guard);
    end
  endtask

  // Present start for one edge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] s, input logic [3:0] esw, input logic [1:0] ek,
                       input logic ez, input int lat, input bit track);
    exp_t e;
    wait_idle();
    start = 1'b1;
    S     = s;
    @(negedge clk);
    start = 1'b0;
    S     = 4'($urandom);
    if (track) begin
      e.sw  = esw;
      e.k   = ek;
      e.z   = ez;
      e.lat = lat;
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    S     = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_outputs", {11'd0, busy, done, zero, k_out == 2'd0, SW_out == 4'd0},
          {11'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    // Round trip with barrel_shift, SW=0001 and k=0..3.
    issue(4'b0001, 4'b0001, 2'd0, 1'b0, 1, 1'b1);
    issue(4'b0010, 4'b0001, 2'd1, 1'b0, 2, 1'b1);
    issue(4'b0100, 4'b0001, 2'd2, 1'b0, 3, 1'b1);
    issue(4'b1000, 4'b0001, 2'd3, 1'b0, 4, 1'b1);
    // Multi-bit words and the all-zero word.
    issue(4'b0110, 4'b0011, 2'd1, 1'b0, 2, 1'b1);
    issue(4'b1010, 4'b0101, 2'd1, 1'b0, 2, 1'b1);
    issue(4'b0000, 4'b0000, 2'd0, 1'b1, 1, 1'b1);
    issue(4'b1111, 4'b1111, 2'd0, 1'b0, 1, 1'b1);

    // A start pulse while busy is ignored.
    issue(4'b1000, 4'b0001, 2'd3, 1'b0, 4, 1'b1);
    @(negedge clk);
    start = 1'b1;
    S     = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("busy_after_ignored", {15'd0, busy}, 16'd0);

    // A start held high through SHIFT and DONE is not accepted.
    issue(4'b0010, 4'b0001, 2'd1, 1'b0, 2, 1'b1);
    start = 1'b1;
    S     = 4'b0001;
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_held_start", {15'd0, busy}, 16'd0);
    repeat (4) @(negedge clk);
    check("still_idle_after_held", {14'd0, busy, done}, 16'd0);

    // Reset one cycle after accept aborts the request and clears results.
    issue(4'b1000, 4'b0001, 2'd3, 1'b0, 4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {8'd0, busy, done, zero, k_out, SW_out[2:0]},
          {8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0});
    check("abort_sw_msb", {15'd0, SW_out[3]}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(4'b0010, 4'b0001, 2'd1, 1'b0, 2, 1'b1);

    // Results hold with start low after the S=0100 decode.
    issue(4'b0100, 4'b0001, 2'd2, 1'b0, 3, 1'b1);
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_%0d", i), {8'd0, busy, done, k_out, SW_out}, {8'd0, 1'b0, 1'b0, 2'd2, 4'b0001});
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/barrel_unshift.md
# barrel_unshift

Sequential inverse of the 4-bit `barrel_shift` datapath. It takes a left-shifted word `S` and recovers the unshifted value `SW_out` and the shift amount `k_out`. It shifts right one position per clock until the LSB is 1 or the maximum shift is reached. It sits on the receive side of the shifter, so the lab bench can close the loop (`SW`,`k` → `S` → `SW_out`,`k_out`) and check it.

## Interface
Parameters:
- `W`, 4, data width of `S` and `SW_out`
- `KW`, 2, width of `k_out`; `MAXK` = min(2^KW − 1, W − 1), which is 3 at defaults

Ports:
- `clk`  in  1  rising-edge clock; the block has one clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE
- `S`  in  W  shifted word; captured on the edge that accepts `start`
- `busy`  out  1  high in SHIFT and DONE
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward
- `SW_out`  out  W  recovered (right-aligned) word
- `k_out`  out  KW  recovered shift amount
- `zero`  out  1  set when the captured `S` was all zeros

## Operation
- Internal state: shift register `sr[W-1:0]` and counter `cnt[KW-1:0]`.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on an edge with `start`=1, load `sr`←`S` and `cnt`←0, then go to SHIFT. With `start`=0, stay in IDLE.
- SHIFT: each edge evaluates these rules in priority order.
  - 1. `sr`==0: go to DONE. Set `SW_out`←0, `k_out`←0, `zero`←1.
  - 2. `sr[0]`==1 or `cnt`==MAXK: go to DONE. Set `SW_out`←`sr`, `k_out`←`cnt`, `zero`←0.
  - 3. Otherwise: `sr`←`sr`>>1 with zero fill, `cnt`←`cnt`+1, and stay in SHIFT.
- DONE: `done`=1 for exactly this one cycle, then go to IDLE unconditionally. A `start` seen in DONE is ignored.
- `start` is ignored in SHIFT and DONE and is never queued. The requester must wait for `busy`=0.
- Result registers (`SW_out`, `k_out`, `zero`) change only on entry to DONE. They hold until the next DONE entry.
- Saturation: if `S` has more than MAXK trailing zeros, the result is `k_out`=MAXK and `SW_out`=`S`>>MAXK. With W=4 and MAXK=3 this case cannot occur for nonzero `S`.
- `cnt` never wraps, because rule 2 stops it at MAXK.
- Ambiguity is resolved as the minimal-k decode: `SW_out` always has LSB=1 unless `zero`=1. Example: `S`=0100 decodes to 0001,k=2, never to 0010,k=1.

## Timing
- Reset (`rst_n`=0, asynchronous): state←IDLE, `sr`←0, `cnt`←0.
- Reset values of all outputs: `busy`=0, `done`=0, `SW_out`=0, `k_out`=0, `zero`=0.
- Reset mid-operation aborts the request: no `done` pulse is produced and the results are cleared.
- `busy` and `done` are decoded from registered state, so they are glitch-free.
- Latency, with `start` accepted at edge E0 and t = trailing zeros of `S` (t ≤ MAXK):
  - the FSM enters DONE at edge E(t+1);
  - `done` is high between E(t+1) and E(t+2);
  - `busy` is high from E0 to E(t+2);
  - the earliest next accept is at edge E(t+2).
- `S`=0: DONE is entered at E1, the same latency as t=0.
- Worst case at defaults: 5 cycles from accept to return to IDLE.
- `S` may change freely after the accept edge.

## Test plan
- Round trip with `barrel_shift`: drive `SW`=01 with `k`=0,1,2,3, giving `S`=0001, 0010, 0100, 1000, each fed to `start` → `SW_out`=0001 and `k_out` equal to the driven `k`. `done` must arrive 1, 2, 3 and 4 cycles after accept respectively.
- `S`=0110 → `SW_out`=0011, `k_out`=1, `zero`=0, `done` 2 cycles after accept. `S`=1010 → `SW_out`=0101, `k_out`=1.
- `S`=0000 → `zero`=1, `SW_out`=0000, `k_out`=0, `done` 1 cycle after accept.
- Pulse `start` with `S`=0001 while busy on a prior `S`=1000 → the second request is ignored. Result is `k_out`=3 with exactly one `done` pulse. A `start` held high into DONE is also not accepted.
- Assert `rst_n`=0 one cycle after accepting `S`=1000 → all outputs 0 immediately and no `done` pulse. After release, `S`=0010 → `k_out`=1.
- Hold check: after the `S`=0100 decode, leave `start`=0 for 10 cycles → `SW_out`=0001 and `k_out`=2 are stable, with `busy`=0 and `done`=0.
